// File: rtl/mpc_vec_bank_resp_pkg.sv
// Shared constants and types for the vector bank responder.
// One 24-entry Q16.16 vector, a three-state load/unload FSM and sticky error bits.
package mpc_pkg;

    localparam int MPC_VEC_DEPTH = 24;
    localparam int MPC_AW        = 5;
    localparam int MPC_DW        = 32;

    // Index of the final vector entry; also the point where streams end.
    localparam logic [MPC_AW-1:0] MPC_LAST_IDX = 5'd23;

    // Bit positions inside the sticky error vector.
    localparam int MPC_ERR_W     = 3;
    localparam int MPC_ERR_BUSY  = 0;
    localparam int MPC_ERR_ADDR  = 1;
    localparam int MPC_ERR_TLAST = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_UNLOAD = 2'd2
    } mpc_state_e;

    // True when an address falls inside the vector.
    function automatic logic mpc_addr_ok(input logic [MPC_AW-1:0] addr);
        return (addr <= MPC_LAST_IDX);
    endfunction

endpackage

// File: rtl/mpc_vec_ram_1r1w.sv
// DEPTH x DW storage with one registered read port and one write port.
// Read-first: a read and a write to the same entry on one edge return the old word.
// Contents are never reset; only the read register is.
module mpc_vec_ram_1r1w
    import mpc_pkg::*;
#(
    parameter int DEPTH = MPC_VEC_DEPTH,
    parameter int AW    = MPC_AW,
    parameter int DW    = MPC_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] q_r;

    // Array write; the caller guarantees waddr is in range whenever we is high.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read; holds its value when no read is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {DW{1'b0}};
        end else if (re) begin
            q_r <= mem_r[raddr];
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/mpc_vec_bank_resp.sv
// Memory-side responder for the vector kernels.
// In IDLE the kernel owns both RAM ports; LOAD hands the write port to the
// AXI-Stream loader and UNLOAD hands the read port to the stream unloader.
// Data is stored and returned bit-exact; no arithmetic happens here.
module mpc_vec_bank_resp
    import mpc_pkg::*;
(
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [MPC_AW-1:0]    rd_address0,
    input  logic                 rd_ce0,
    output logic [MPC_DW-1:0]    rd_q0,
    input  logic [MPC_AW-1:0]    wr_address0,
    input  logic                 wr_ce0,
    input  logic                 wr_we0,
    input  logic [MPC_DW-1:0]    wr_d0,
    input  logic                 load_start,
    input  logic                 unload_start,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic [MPC_DW-1:0]    s_tdata,
    input  logic                 s_tlast,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [MPC_DW-1:0]    m_tdata,
    output logic                 m_tlast,
    output logic                 busy,
    output logic [MPC_ERR_W-1:0] err,
    input  logic                 err_clr
);

    mpc_state_e          state_r;
    logic [MPC_AW-1:0]   cnt_r;
    logic                s_tready_r;
    logic                m_tvalid_r;
    logic                m_tlast_r;
    logic                busy_r;
    logic [MPC_ERR_W-1:0] err_r;
    logic [MPC_DW-1:0]   kq_hold_r;
    logic                kq_show_ram_r;

    logic                load_hs_s;
    logic                load_end_s;
    logic                unload_hs_s;
    logic                unload_end_s;
    logic                cnt_last_s;
    logic                k_wr_s;
    logic                rd_addr_ok_s;
    logic                wr_addr_ok_s;
    logic                k_rd_ok_s;
    logic                k_wr_ok_s;
    logic [MPC_ERR_W-1:0] new_err_s;
    logic [MPC_AW-1:0]   cnt_next_s;

    logic                ram_re_s;
    logic [MPC_AW-1:0]   ram_raddr_s;
    logic [MPC_DW-1:0]   ram_q_s;
    logic                ram_we_s;
    logic [MPC_AW-1:0]   ram_waddr_s;
    logic [MPC_DW-1:0]   ram_wdata_s;
    logic [MPC_DW-1:0]   rd_q0_s;

    // Handshake, address and kernel-access qualification.
    always_comb begin
        cnt_last_s   = (cnt_r == MPC_LAST_IDX);
        cnt_next_s   = cnt_r + 5'd1;
        load_hs_s    = s_tready_r & s_tvalid;
        load_end_s   = load_hs_s & (s_tlast | cnt_last_s);
        unload_hs_s  = m_tvalid_r & m_tready;
        unload_end_s = unload_hs_s & cnt_last_s;
        k_wr_s       = wr_ce0 & wr_we0;
        rd_addr_ok_s = mpc_addr_ok(rd_address0);
        wr_addr_ok_s = mpc_addr_ok(wr_address0);
        k_rd_ok_s    = rd_ce0 & ~busy_r & rd_addr_ok_s;
        k_wr_ok_s    = k_wr_s & ~busy_r & wr_addr_ok_s;
    end

    // New error events this cycle; a tlast mismatch is tlast disagreeing with the final index.
    always_comb begin
        new_err_s                = {MPC_ERR_W{1'b0}};
        new_err_s[MPC_ERR_BUSY]  = busy_r & (rd_ce0 | k_wr_s);
        new_err_s[MPC_ERR_ADDR]  = (rd_ce0 & ~rd_addr_ok_s) | (k_wr_s & ~wr_addr_ok_s);
        new_err_s[MPC_ERR_TLAST] = load_hs_s & (s_tlast ^ cnt_last_s);
    end

    // RAM port steering by state; nothing touches the array on a reset edge.
    always_comb begin
        ram_re_s    = 1'b0;
        ram_raddr_s = {MPC_AW{1'b0}};
        ram_we_s    = 1'b0;
        ram_waddr_s = {MPC_AW{1'b0}};
        ram_wdata_s = {MPC_DW{1'b0}};
        if (ap_rst) begin
            ram_re_s = 1'b0;
            ram_we_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ram_re_s    = k_rd_ok_s;
                    ram_raddr_s = rd_address0;
                    ram_we_s    = k_wr_ok_s;
                    ram_waddr_s = wr_address0;
                    ram_wdata_s = wr_d0;
                end
                ST_LOAD: begin
                    ram_we_s    = load_hs_s;
                    ram_waddr_s = cnt_r;
                    ram_wdata_s = s_tdata;
                end
                ST_UNLOAD: begin
                    // First fetch right after entry, then prefetch on each non-final handshake.
                    ram_re_s    = ~m_tvalid_r | (unload_hs_s & ~cnt_last_s);
                    ram_raddr_s = unload_hs_s ? cnt_next_s : cnt_r;
                end
                default: begin
                    ram_re_s = 1'b0;
                    ram_we_s = 1'b0;
                end
            endcase
        end
    end

    mpc_vec_ram_1r1w #(
        .DEPTH (MPC_VEC_DEPTH),
        .AW    (MPC_AW),
        .DW    (MPC_DW)
    ) u_ram (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .re    (ram_re_s),
        .raddr (ram_raddr_s),
        .q     (ram_q_s),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s)
    );

    // Load/unload sequencer with registered stream controls and busy.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {MPC_AW{1'b0}};
            s_tready_r <= 1'b0;
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_start) begin
                        state_r    <= ST_LOAD;
                        cnt_r      <= {MPC_AW{1'b0}};
                        s_tready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else if (unload_start) begin
                        state_r    <= ST_UNLOAD;
                        cnt_r      <= {MPC_AW{1'b0}};
                        m_tvalid_r <= 1'b0;
                        m_tlast_r  <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (load_end_s) begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= {MPC_AW{1'b0}};
                        s_tready_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end else if (load_hs_s) begin
                        cnt_r <= cnt_next_s;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_UNLOAD: begin
                    if (!m_tvalid_r) begin
                        m_tvalid_r <= 1'b1;
                        m_tlast_r  <= cnt_last_s;
                    end else if (unload_end_s) begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= {MPC_AW{1'b0}};
                        m_tvalid_r <= 1'b0;
                        m_tlast_r  <= 1'b0;
                        busy_r     <= 1'b0;
                    end else if (unload_hs_s) begin
                        cnt_r     <= cnt_next_s;
                        m_tlast_r <= (cnt_next_s == MPC_LAST_IDX);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= {MPC_AW{1'b0}};
                    s_tready_r <= 1'b0;
                    m_tvalid_r <= 1'b0;
                    m_tlast_r  <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Sticky errors: clear first, then OR in this cycle's events so a new error wins.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            err_r <= {MPC_ERR_W{1'b0}};
        end else begin
            err_r <= (err_clr ? {MPC_ERR_W{1'b0}} : err_r) | new_err_s;
        end
    end

    // Kernel read view: show the RAM word after a good read, otherwise a frozen copy.
    // Freezing on idle cycles keeps rd_q0 stable even when the unloader reuses the read port.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            kq_hold_r     <= {MPC_DW{1'b0}};
            kq_show_ram_r <= 1'b0;
        end else if (rd_ce0) begin
            if (k_rd_ok_s) begin
                kq_hold_r     <= kq_hold_r;
                kq_show_ram_r <= 1'b1;
            end else begin
                kq_hold_r     <= {MPC_DW{1'b0}};
                kq_show_ram_r <= 1'b0;
            end
        end else begin
            kq_hold_r     <= rd_q0_s;
            kq_show_ram_r <= 1'b0;
        end
    end

    assign rd_q0_s  = kq_show_ram_r ? ram_q_s : kq_hold_r;
    assign rd_q0    = rd_q0_s;
    assign s_tready = s_tready_r;
    assign m_tvalid = m_tvalid_r;
    assign m_tdata  = m_tvalid_r ? ram_q_s : {MPC_DW{1'b0}};
    assign m_tlast  = m_tlast_r;
    assign busy     = busy_r;
    assign err      = err_r;

endmodule

// File: tb/tb_mpc_vec_bank_resp.sv
// Self-checking bench for mpc_vec_bank_resp: a plain array models the vector,
// a 3-bit variable models the sticky errors; randomized data and stream stalls.
module tb_mpc_vec_bank_resp;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [4:0]  rd_address0;
    logic        rd_ce0;
    logic [31:0] rd_q0;
    logic [4:0]  wr_address0;
    logic        wr_ce0;
    logic        wr_we0;
    logic [31:0] wr_d0;
    logic        load_start;
    logic        unload_start;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        busy;
    logic [2:0]  err;
    logic        err_clr;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m [24];
    logic [31:0] ld_data [24];
    logic [2:0]  err_m;

    mpc_vec_bank_resp dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .rd_address0  (rd_address0),
        .rd_ce0       (rd_ce0),
        .rd_q0        (rd_q0),
        .wr_address0  (wr_address0),
        .wr_ce0       (wr_ce0),
        .wr_we0       (wr_we0),
        .wr_d0        (wr_d0),
        .load_start   (load_start),
        .unload_start (unload_start),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tdata      (s_tdata),
        .s_tlast      (s_tlast),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast),
        .busy         (busy),
        .err          (err),
        .err_clr      (err_clr)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Stream words into the bank; the model applies the same words and tlast rule.
    task automatic drive_load(input int n, input int tlast_idx, input bit with_start);
        if (with_start) begin
            load_start = 1'b1;
            tick();
            load_start = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                tick();
            end
            s_tvalid = 1'b1;
            s_tdata  = ld_data[i];
            s_tlast  = (i == tlast_idx);
            checks++;
            if (s_tready !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL load_ready word %0d: s_tready=%b busy=%b expected 1/1", i, s_tready, busy);
            end
            tick();
            mem_m[i] = ld_data[i];
            if ((i == 23) != (i == tlast_idx)) err_m[2] = 1'b1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (rd_q0 !== 32'h0 || s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tdata !== 32'h0 ||
            m_tlast !== 1'b0 || busy !== 1'b0 || err !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: rd_q0=%h s_tready=%b m_tvalid=%b m_tdata=%h m_tlast=%b busy=%b err=%b expected all zero",
                     rd_q0, s_tready, m_tvalid, m_tdata, m_tlast, busy, err);
        end
    endtask

    task automatic test_load_full();
        for (int i = 0; i < 24; i++) ld_data[i] = 32'(i) << 16;
        drive_load(24, 23, 1'b1);
        checks++;
        if (busy !== 1'b0 || s_tready !== 1'b0 || err !== err_m) begin
            errors++;
            $display("FAIL load_full_end: busy=%b s_tready=%b err=%b expected 0/0/%b", busy, s_tready, err, err_m);
        end
        rd_ce0 = 1'b1;
        rd_address0 = 5'd5;
        tick();
        rd_ce0 = 1'b0;
        checks++;
        if (rd_q0 !== 32'h00050000) begin
            errors++;
            $display("FAIL kernel_read_addr5: got %h expected %h", rd_q0, 32'h00050000);
        end
    endtask

    task automatic test_unload(input bit random_ready);
        logic [3:0] pat;
        int beat;
        int cyc;
        bit hs;
        pat = 4'b1001;
        unload_start = 1'b1;
        tick();
        unload_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL unload_entry: busy=%b m_tvalid=%b expected 1/0", busy, m_tvalid);
        end
        beat = 0;
        cyc = 0;
        while (beat < 24 && cyc < 400) begin
            m_tready = random_ready ? 1'($urandom_range(0, 1)) : pat[cyc % 4];
            if (cyc > 0) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== mem_m[beat] || m_tlast !== (beat == 23)) begin
                    errors++;
                    $display("FAIL unload_beat %0d: m_tvalid=%b m_tdata=%h m_tlast=%b expected 1/%h/%b",
                             beat, m_tvalid, m_tdata, m_tlast, mem_m[beat], (beat == 23));
                end
            end
            hs = (m_tvalid === 1'b1) && m_tready;
            tick();
            cyc++;
            if (hs) beat++;
        end
        m_tready = 1'b0;
        checks++;
        if (beat != 24 || m_tvalid !== 1'b0 || busy !== 1'b0 || m_tlast !== 1'b0) begin
            errors++;
            $display("FAIL unload_end: beats=%0d m_tvalid=%b busy=%b m_tlast=%b expected 24/0/0/0",
                     beat, m_tvalid, busy, m_tlast);
        end
    endtask

    task automatic read_all_and_check(input string tag);
        for (int a = 0; a < 24; a++) begin
            rd_ce0 = 1'b1;
            rd_address0 = 5'(a);
            tick();
            checks++;
            if (rd_q0 !== mem_m[a]) begin
                errors++;
                $display("FAIL %s addr %0d: got %h expected %h", tag, a, rd_q0, mem_m[a]);
            end
        end
        rd_ce0 = 1'b0;
    endtask

    task automatic test_load_early_tlast();
        for (int i = 0; i < 24; i++) ld_data[i] = $urandom;
        drive_load(10, 9, 1'b1);
        checks++;
        if (err !== 3'b100 || busy !== 1'b0 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL early_tlast: err=%b busy=%b s_tready=%b expected 100/0/0", err, busy, s_tready);
        end
        read_all_and_check("early_tlast_mem");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        err_m = 3'b000;
        checks++;
        if (err !== 3'b000) begin
            errors++;
            $display("FAIL err_clr_after_tlast: got %b expected 000", err);
        end
    endtask

    task automatic test_collision();
        logic [31:0] old_v;
        old_v = mem_m[3];
        wr_ce0 = 1'b1; wr_we0 = 1'b1; wr_address0 = 5'd3; wr_d0 = 32'hFFFF8000;
        rd_ce0 = 1'b1; rd_address0 = 5'd3;
        tick();
        mem_m[3] = 32'hFFFF8000;
        wr_ce0 = 1'b0; wr_we0 = 1'b0;
        checks++;
        if (rd_q0 !== old_v) begin
            errors++;
            $display("FAIL collision_read_first: got %h expected %h", rd_q0, old_v);
        end
        tick();
        rd_ce0 = 1'b0;
        checks++;
        if (rd_q0 !== 32'hFFFF8000) begin
            errors++;
            $display("FAIL collision_new_value: got %h expected %h", rd_q0, 32'hFFFF8000);
        end
        tick();
        tick();
        checks++;
        if (rd_q0 !== 32'hFFFF8000) begin
            errors++;
            $display("FAIL read_hold: got %h expected %h", rd_q0, 32'hFFFF8000);
        end
    endtask

    task automatic test_errors();
        logic [31:0] keep15;
        rd_ce0 = 1'b1; rd_address0 = 5'd24;
        tick();
        rd_ce0 = 1'b0;
        err_m[1] = 1'b1;
        checks++;
        if (rd_q0 !== 32'h0 || err !== 3'b010) begin
            errors++;
            $display("FAIL addr_range_read: rd_q0=%h err=%b expected 0/010", rd_q0, err);
        end
        err_clr = 1'b1;
        tick();
        err_m = 3'b000;
        checks++;
        if (err !== 3'b000) begin
            errors++;
            $display("FAIL err_clr: got %b expected 000", err);
        end
        // clear and a fresh out-of-range write on the same edge: the new error stays
        wr_ce0 = 1'b1; wr_we0 = 1'b1; wr_address0 = 5'd30; wr_d0 = $urandom;
        tick();
        err_clr = 1'b0; wr_ce0 = 1'b0; wr_we0 = 1'b0;
        err_m[1] = 1'b1;
        checks++;
        if (err !== 3'b010) begin
            errors++;
            $display("FAIL err_clr_vs_new: got %b expected 010", err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        err_m = 3'b000;
        // kernel access during LOAD is dropped and flagged; stray unload_start ignored
        keep15 = mem_m[15];
        for (int i = 0; i < 24; i++) ld_data[i] = $urandom;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        rd_ce0 = 1'b1; rd_address0 = 5'd5;
        wr_ce0 = 1'b1; wr_we0 = 1'b1; wr_address0 = 5'd15; wr_d0 = ~keep15;
        unload_start = 1'b1;
        tick();
        rd_ce0 = 1'b0; wr_ce0 = 1'b0; wr_we0 = 1'b0; unload_start = 1'b0;
        err_m[0] = 1'b1;
        checks++;
        if (rd_q0 !== 32'h0 || err !== err_m || s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL busy_access: rd_q0=%h err=%b s_tready=%b m_tvalid=%b expected 0/%b/1/0",
                     rd_q0, err, s_tready, m_tvalid, err_m);
        end
        drive_load(3, 2, 1'b0);
        checks++;
        if (err !== 3'b101 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_then_tlast: err=%b busy=%b expected 101/0", err, busy);
        end
        read_all_and_check("busy_write_dropped");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        err_m = 3'b000;
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 24; i++) ld_data[i] = $urandom;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_tvalid = 1'b1; s_tdata = ld_data[i]; s_tlast = 1'b0;
            tick();
            mem_m[i] = ld_data[i];
        end
        s_tdata = ld_data[7];
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        s_tvalid = 1'b0;
        err_m = 3'b000;
        checks++;
        if (busy !== 1'b0 || s_tready !== 1'b0 || m_tvalid !== 1'b0 || err !== 3'b000 || rd_q0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_load: busy=%b s_tready=%b m_tvalid=%b err=%b rd_q0=%h expected all zero",
                     busy, s_tready, m_tvalid, err, rd_q0);
        end
        read_all_and_check("reset_mid_load_mem");
    endtask

    task automatic test_start_priority();
        for (int i = 0; i < 24; i++) ld_data[i] = $urandom;
        load_start = 1'b1;
        unload_start = 1'b1;
        tick();
        load_start = 1'b0;
        unload_start = 1'b0;
        tick();
        checks++;
        if (s_tready !== 1'b1 || busy !== 1'b1 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL start_priority: s_tready=%b busy=%b m_tvalid=%b expected 1/1/0", s_tready, busy, m_tvalid);
        end
        drive_load(24, 23, 1'b0);
        checks++;
        if (busy !== 1'b0 || err !== err_m) begin
            errors++;
            $display("FAIL priority_load_end: busy=%b err=%b expected 0/%b", busy, err, err_m);
        end
    endtask

    task automatic test_random_kernel();
        logic [31:0] exp_q;
        int ra;
        int wa;
        bit do_wr;
        exp_q = rd_q0;
        rd_ce0 = 1'b1; rd_address0 = 5'd0;
        tick();
        exp_q = mem_m[0];
        for (int c = 0; c < 80; c++) begin
            rd_ce0 = 1'($urandom_range(0, 1));
            ra = $urandom_range(0, 26);
            rd_address0 = 5'(ra);
            wr_ce0 = 1'($urandom_range(0, 1));
            wr_we0 = 1'($urandom_range(0, 1));
            wa = $urandom_range(0, 26);
            wr_address0 = 5'(wa);
            wr_d0 = $urandom;
            do_wr = wr_ce0 && wr_we0;
            if (rd_ce0) begin
                exp_q = (ra < 24) ? mem_m[ra] : 32'h0;
                if (ra >= 24) err_m[1] = 1'b1;
            end
            if (do_wr) begin
                if (wa < 24) mem_m[wa] = wr_d0;
                else err_m[1] = 1'b1;
            end
            tick();
            checks++;
            if (rd_q0 !== exp_q || err !== err_m) begin
                errors++;
                $display("FAIL random_kernel cycle %0d: rd_q0=%h err=%b expected %h/%b", c, rd_q0, err, exp_q, err_m);
            end
        end
        rd_ce0 = 1'b0; wr_ce0 = 1'b0; wr_we0 = 1'b0;
    endtask

    initial begin
        ap_rst = 1'b1;
        rd_address0 = 5'd0; rd_ce0 = 1'b0;
        wr_address0 = 5'd0; wr_ce0 = 1'b0; wr_we0 = 1'b0; wr_d0 = 32'h0;
        load_start = 1'b0; unload_start = 1'b0;
        s_tvalid = 1'b0; s_tdata = 32'h0; s_tlast = 1'b0;
        m_tready = 1'b0; err_clr = 1'b0;
        err_m = 3'b000;
        tick();
        tick();
        ap_rst = 1'b0;
        test_reset();
        test_load_full();
        test_unload(1'b0);
        test_load_early_tlast();
        test_collision();
        test_errors();
        test_reset_mid_load();
        test_start_priority();
        test_unload(1'b1);
        test_random_kernel();
        test_unload(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
